batchnorm_normalizer: RTL and testbench

Downstream consumer of the batch-statistics accumulator: takes the batch `mean`/`varr` plus affine parameters `gamma`/`beta` and normalises a sample stream as y = gamma·(x − mean)/sqrt(varr + EPS) + beta. The block builds a per-batch scale factor with a sequential square root and a sequential divider. It then streams samples through a 2-stage pipeline with valid/ready handshakes on both sides. All values are fixed point with FRAC fractional bits.

---
 rtl/batchnorm_normalizer.sv | 201 ++++++++++++++++++++
 tb/tb_batchnorm_normalizer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batchnorm_normalizer.sv
// batchnorm_normalizer
//   Turns batch statistics (mean, varr) and affine parameters (gamma, beta)
//   into a per-batch scale = gamma / sqrt(varr + EPS). The square root and
//   the divide are both bit-serial. Samples are then streamed through a
//   2-stage pipeline: y = sat(((x - mean) * scale) >>> FRAC + beta).
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   stats_valid       one-cycle pulse capturing mean/varr/gamma/beta
//   mean, varr        unsigned batch statistics (Q.FRAC)
//   gamma, beta       signed affine parameters (Q.FRAC)
//   x_in/x_valid/x_ready   sample input handshake (x_in unsigned)
//   y_out/y_valid/y_ready  normalised output handshake (y_out signed)
//   busy              scale computation or commit in progress
module batchnorm_normalizer #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int EPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stats_valid,
  input  logic [WIDTH-1:0] mean,
  input  logic [WIDTH-1:0] varr,
  input  logic [WIDTH-1:0] gamma,
  input  logic [WIDTH-1:0] beta,
  input  logic [WIDTH-1:0] x_in,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [WIDTH-1:0] y_out,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             busy
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(W2);
  localparam logic [W2-1:0]   QMAX = {{WIDTH{1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [W2+1:0] YMAX = {{(W2+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [W2+1:0] YMIN = {{(W2+3-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SQRT, DIV, COMMIT, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] wk_mean_q, wk_gamma_q, wk_beta_q;
  logic [W2-1:0]    rad_q;    // radicand, consumed two bits per step
  logic [WIDTH-1:0] srem_q;   // square-root partial remainder
  logic [WIDTH-1:0] root_q;   // square-root result, later the divisor
  logic [W2-1:0]    dq_q;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] drem_q;   // division partial remainder

  logic [WIDTH-1:0]        act_mean_q;
  logic signed [WIDTH-1:0] act_scale_q, act_beta_q;

  logic signed [WIDTH:0]   d_p1_q;
  logic                    vld_p1_q;
  logic signed [WIDTH-1:0] y_p2_q;
  logic                    vld_p2_q;

  logic adv, x_acc, pipe_empty, commit_go;
  logic [WIDTH+1:0] s_sh, s_trial;
  logic             s_ge;
  logic [WIDTH:0]   dv_sh;
  logic             dv_ge;
  logic [WIDTH-1:0] g_abs;
  logic signed [W2:0]   p_p1;
  logic signed [W2+1:0] r_p1;

  // Saturate the unsigned quotient magnitude, with gamma's sign, to signed WIDTH.
  function automatic logic signed [WIDTH-1:0] sat_scale(input logic [W2-1:0] q,
                                                        input logic neg);
    if (q > QMAX) return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return neg ? -q[WIDTH-1:0] : q[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_y(input logic signed [W2+1:0] r);
    if (r > YMAX) return {1'b0, {(WIDTH-1){1'b1}}};
    if (r < YMIN) return {1'b1, {(WIDTH-1){1'b0}}};
    return r[WIDTH-1:0];
  endfunction

  always_comb begin
    adv        = !vld_p2_q || y_ready;
    x_ready    = (state_q == RUN) && adv;
    x_acc      = x_valid && x_ready;
    busy       = (state_q == SQRT) || (state_q == DIV) || (state_q == COMMIT);
    pipe_empty = !vld_p1_q && !vld_p2_q;
    commit_go  = (state_q == COMMIT) && pipe_empty && !stats_valid;
    // Restoring square root step: bring down two radicand bits, try (root<<2)|1.
    s_sh    = {srem_q, rad_q[W2-1:W2-2]};
    s_trial = {root_q, 2'b01};
    s_ge    = s_sh >= s_trial;
    // Restoring division step: bring down one dividend bit, try the divisor.
    dv_sh   = {drem_q, dq_q[W2-1]};
    dv_ge   = dv_sh >= {1'b0, root_q};
    g_abs   = wk_gamma_q[WIDTH-1] ? (~wk_gamma_q + WIDTH'(1)) : wk_gamma_q;
    p_p1    = (W2+1)'(d_p1_q) * (W2+1)'(act_scale_q);
    r_p1    = (W2+2)'(p_p1 >>> FRAC) + (W2+2)'(act_beta_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stats_valid) begin
      state_d = SQRT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SQRT: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DIV;
            cnt_d   = '0;
          end
        end
        DIV: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W2 - 1)) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end
        end
        COMMIT:  if (pipe_empty) state_d = RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scale computation: capture, bit-serial sqrt, bit-serial divide, commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wk_mean_q   <= '0;
      wk_gamma_q  <= '0;
      wk_beta_q   <= '0;
      rad_q       <= '0;
      srem_q      <= '0;
      root_q      <= '0;
      dq_q        <= '0;
      drem_q      <= '0;
      act_mean_q  <= '0;
      act_scale_q <= '0;
      act_beta_q  <= '0;
    end else begin
      if (stats_valid) begin
        wk_mean_q  <= mean;
        wk_gamma_q <= gamma;
        wk_beta_q  <= beta;
        rad_q      <= (W2'(varr) + W2'(EPS)) << FRAC;
        srem_q     <= '0;
        root_q     <= '0;
      end else if (state_q == SQRT) begin
        rad_q  <= rad_q << 2;
        srem_q <= s_ge ? WIDTH'(s_sh - s_trial) : WIDTH'(s_sh);
        root_q <= {root_q[WIDTH-2:0], s_ge};
        // Dividend is independent of the root, so load it on the last sqrt step.
        if (cnt_q == CW'(WIDTH - 1)) begin
          dq_q   <= W2'(g_abs) << FRAC;
          drem_q <= '0;
        end
      end else if (state_q == DIV) begin
        dq_q   <= {dq_q[W2-2:0], dv_ge};
        drem_q <= dv_ge ? WIDTH'(dv_sh - {1'b0, root_q}) : WIDTH'(dv_sh);
      end
      if (commit_go) begin
        act_mean_q  <= wk_mean_q;
        act_scale_q <= sat_scale(dq_q, wk_gamma_q[WIDTH-1]);
        act_beta_q  <= wk_beta_q;
      end
    end
  end

  // Stage 1: centre the accepted sample.
  // Stage 2: scale, shift, add beta, saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_p1_q   <= '0;
      vld_p1_q <= 1'b0;
      y_p2_q   <= '0;
      vld_p2_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= x_acc;
      if (x_acc) d_p1_q <= {1'b0, x_in} - {1'b0, act_mean_q};
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) y_p2_q <= sat_y(r_p1);
    end
  end

  assign y_out   = y_p2_q;
  assign y_valid = vld_p2_q;

endmodule

// File: tb/tb_batchnorm_normalizer.sv
module tb_batchnorm_normalizer;
  localparam int W = 16;
  localparam int F = 8;
  localparam int E = 1;

  logic clk = 1'b0;
  logic rst, stats_valid, x_valid, x_ready, y_valid, y_ready, busy;
  logic [W-1:0] mean, varr, gamma, beta, x_in, y_out;

  always #5 clk = ~clk;

  batchnorm_normalizer #(.WIDTH(W), .FRAC(F), .EPS(E)) dut (
    .clk(clk), .rst(rst), .stats_valid(stats_valid),
    .mean(mean), .varr(varr), .gamma(gamma), .beta(beta),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int exp_q[$];
  int out_log[$];
  longint act_mean = 0, act_scale = 0, act_beta = 0;

  // ---------------- behavioural model ----------------
  function automatic longint isqrt(longint r);
    longint s = 0;
    while ((s + 1) * (s + 1) <= r) s++;
    return s;
  endfunction

  function automatic longint sat16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint to_signed16(longint v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic longint m_scale(longint v, longint g_raw);
    longint g, ag, sd, q;
    g  = to_signed16(g_raw);
    ag = (g < 0) ? -g : g;
    sd = isqrt((v + E) * 256);
    q  = (ag * 256) / sd;
    return sat16((g < 0) ? -q : q);
  endfunction

  function automatic int m_y(longint x, longint m, longint s, longint b);
    longint d, r;
    d = x - m;
    r = ((d * s) >>> F) + b;
    return int'(sat16(r)) & 32'h0000_FFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (busy) check("xready_while_busy", 32'(x_ready), 32'd0);
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_output: got 0x%0h, want no output", y_out);
        end else begin
          check("y_out_vs_model", 32'(y_out), 32'(exp_q.pop_front()));
        end
        out_log.push_back(int'(y_out));
      end
      if (x_valid && x_ready) begin
        exp_q.push_back(m_y(longint'(x_in), act_mean, act_scale, act_beta));
        acc_cnt++;
      end
      if (stats_valid) begin
        act_mean  = longint'(mean);
        act_scale = m_scale(longint'(varr), longint'(gamma));
        act_beta  = to_signed16(longint'(beta));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int m, input int v, input int g, input int b);
    mean = W'(m); varr = W'(v); gamma = W'(g); beta = W'(b);
    stats_valid = 1'b1;
    tick();
    stats_valid = 1'b0;
  endtask

  task automatic measure_busy(input string name);
    int n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check({name, "_busy_cycles"}, 32'(n), 32'd49);
    check({name, "_xready_up"}, 32'(x_ready), 32'd1);
    tick();
  endtask

  task automatic send(input int x);
    bit done = 1'b0;
    x_in = W'(x);
    x_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = x_ready;
      tick();
    end
    x_valid = 1'b0;
    if (!done) fail_now("send_accept");
  endtask

  task automatic expect_out(input string name, input int v);
    for (int i = 0; i < 200 && out_log.size() == 0; i++) @(negedge clk);
    if (out_log.size() == 0) fail_now(name);
    else check(name, 32'(out_log.pop_front()), 32'(v));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_xready"}, 32'(x_ready), 32'd0);
    check({name, "_yvalid"}, 32'(y_valid), 32'd0);
    check({name, "_yout"},   32'(y_out),   32'd0);
    check({name, "_busy"},   32'(busy),    32'd0);
  endtask

  task automatic check_idle_refuses(input string name);
    x_valid = 1'b1;
    x_in = 16'h0600;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(name, 32'(x_ready), 32'd0);
      tick();
    end
    x_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    rst = 1'b1; stats_valid = 1'b0; x_valid = 1'b0; y_ready = 1'b1;
    mean = '0; varr = '0; gamma = '0; beta = '0; x_in = '0;

    // Model pins against hand-computed values.
    check("pin_std",     32'(isqrt((16'h0400 + E) * 256)), 32'h0200);
    check("pin_scale",   32'(m_scale(16'h0400, 16'h0100)), 32'h0080);
    check("pin_y_pos",   32'(m_y(16'h0600, 16'h0200, 128, 0)), 32'h0200);
    check("pin_y_neg",   32'(m_y(16'h0100, 16'h0200, 128, 0)), 32'hFF80);

    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_idle_refuses("idle_no_accept");

    // Basic normalisation with latency check.
    pulse(16'h0200, 16'h0400, 16'h0100, 0);
    measure_busy("basic");
    x_in = 16'h0600; x_valid = 1'b1;
    @(negedge clk);
    check("basic_accept", 32'(x_ready), 32'd1);
    tick();
    x_valid = 1'b0;
    @(negedge clk);
    check("lat_early_yvalid", 32'(y_valid), 32'd0);
    tick();
    @(negedge clk);
    check("lat_yvalid", 32'(y_valid), 32'd1);
    check("lat_yout",   32'(y_out),   32'h0200);
    tick();
    out_log.delete();
    send(16'h0100);
    expect_out("basic_neg", 16'hFF80);

    // Saturation and beta.
    pulse(0, 0, 16'h7FFF, 0);
    measure_busy("sat_pos");
    out_log.delete();
    send(16'hFF00);
    expect_out("sat_pos_y", 16'h7FFF);
    pulse(0, 0, 16'h8000, 0);
    measure_busy("sat_neg");
    send(16'hFF00);
    expect_out("sat_neg_y", 16'h8000);
    pulse(16'h0200, 16'h0400, 16'h0100, 16'h0100);
    measure_busy("beta");
    send(16'h0600);
    expect_out("beta_y", 16'h0300);

    // Backpressure: 6 samples, y_ready low for 5 cycles.
    pulse(16'h0200, 16'h0400, 16'h0100, 0);
    measure_busy("bp");
    out_log.delete();
    base = acc_cnt;
    fork
      begin
        y_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_held_two", 32'(acc_cnt - base), 32'd2);
        check("bp_xready_low", 32'(x_ready), 32'd0);
        y_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) send(16'h0200 + i * 16'h0100);
      end
    join
    for (int i = 0; i < 6; i++) expect_out("bp_order", m_y(16'h0200 + i * 16'h0100, 16'h0200, 128, 0));

    // Restart 10 cycles into SQRT: second statistics win.
    pulse(16'h0200, 16'h0400, 16'h0100, 0);
    repeat (9) tick();
    pulse(16'h0100, 16'h0400, 16'h0200, 0);
    measure_busy("restart_sqrt");
    out_log.delete();
    send(16'h0600);
    expect_out("restart_sqrt_y", 16'h0500);

    // Restart in RUN with two samples in flight (second coincides with the pulse).
    pulse(16'h0200, 16'h0400, 16'h0100, 0);
    measure_busy("run_a");
    out_log.delete();
    x_in = 16'h0600; x_valid = 1'b1;
    @(negedge clk);
    check("run_acc_a", 32'(x_ready), 32'd1);
    tick();
    mean = 16'h0100; varr = 16'h0400; gamma = 16'h0200; beta = 16'h0000;
    stats_valid = 1'b1;
    @(negedge clk);
    check("run_acc_b", 32'(x_ready), 32'd1);
    tick();
    stats_valid = 1'b0; x_valid = 1'b0;
    check("run_xready_drop", 32'(x_ready), 32'd0);
    measure_busy("run_b");
    send(16'h0600);
    expect_out("run_old_1", 16'h0200);
    expect_out("run_old_2", 16'h0200);
    expect_out("run_new",   16'h0500);

    // Randomised stream with occasional statistics updates.
    pulse($urandom & 16'hFFFF, $urandom & 16'h0FFF, $urandom & 16'hFFFF, $urandom & 16'hFFFF);
    for (int c = 0; c < 3000; c++) begin
      x_valid = ($urandom % 4) != 0;
      x_in    = W'($urandom);
      y_ready = ($urandom % 4) != 0;
      if ($urandom % 300 == 0) begin
        mean  = W'($urandom);
        varr  = ($urandom % 2) ? W'($urandom % 64) : W'($urandom);
        gamma = W'($urandom);
        beta  = W'($urandom);
        stats_valid = 1'b1;
      end else begin
        stats_valid = 1'b0;
      end
      tick();
    end
    stats_valid = 1'b0; x_valid = 1'b0; y_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream.
    pulse(16'h0200, 16'h0400, 16'h0100, 0);
    measure_busy("pre_rst");
    x_valid = 1'b1; x_in = 16'h0600; y_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    rst = 1'b0; y_ready = 1'b1; x_valid = 1'b0;
    tick();
    check_idle_refuses("rst_idle");

    // Reset mid-DIV, then a fresh computation.
    pulse(16'h0200, 16'h0400, 16'h0100, 0);
    repeat (19) tick();
    rst = 1'b1;
    #1;
    check("rst_div_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_div_idle_busy", 32'(busy), 32'd0);
    pulse(16'h0200, 16'h0400, 16'h0100, 0);
    measure_busy("rst_div");
    out_log.delete();
    send(16'h0600);
    expect_out("rst_div_y", 16'h0200);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
